// File: rtl/mult_share_pkg.sv
// Shared types and default widths for the multiplier-sharing arbiter.
// The optional MULT_SHARE_STATS_EN build uses OP_CNT_W for its handshake counter.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int A_W_DEF   = 3;
  localparam int B_W_DEF   = 3;
  localparam int N_REQ_DEF = 4;
  localparam int OP_CNT_W  = 16;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last grant and wraps,
// so the most recently served requester is always lowest priority.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_pos         = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos = IDX_W'((int'(i_last_grant) + k) % N_REQ);
      if (!o_grant_valid && i_req_valid[w_pos]) begin
        o_grant_valid  = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_grant_idx    = w_pos;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// One registered unsigned multiplier shared by N_REQ requesters through an IDLE/CALC/RESP
// sequencer. Define MULT_SHARE_STATS_EN to add a saturating op_count output.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int A_W   = A_W_DEF,
  parameter  int B_W   = B_W_DEF,
  localparam int RES_W = A_W + B_W,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  output logic [IDX_W-1:0]     rsp_id,
  output logic [RES_W-1:0]     rsp_result,
  input  logic                 rsp_ready,
  output logic                 busy
`ifdef MULT_SHARE_STATS_EN
  ,
  output logic [OP_CNT_W-1:0]  op_count
`endif
);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_last_grant, r_id;
  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_grant_valid;
  logic             w_req_fire, w_mul_en, w_rsp_fire;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_grant_valid(w_grant_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_req_fire  = 1'b0;
    w_mul_en    = 1'b0;
    w_rsp_fire  = 1'b0;
    unique case (r_state)
      IDLE: if (w_grant_valid) begin
        w_req_fire  = 1'b1;
        w_state_nxt = CALC;
      end
      CALC: begin
        w_mul_en    = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: if (rsp_ready) begin
        w_rsp_fire  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grants are suppressed while reset is held so nothing handshakes into a discarded op.
  assign req_ready = (rst && r_state == IDLE) ? w_grant : '0;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
    end else begin
      if (w_req_fire) begin
        r_a          <= req_a[w_grant_idx*A_W +: A_W];
        r_b          <= req_b[w_grant_idx*B_W +: B_W];
        r_id         <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
      if (w_mul_en) begin
        rsp_result <= RES_W'(r_a) * RES_W'(r_b);
        rsp_id     <= r_id;
        rsp_valid  <= 1'b1;
      end
      if (w_rsp_fire) rsp_valid <= 1'b0;
    end
  end

`ifdef MULT_SHARE_STATS_EN
  logic [OP_CNT_W-1:0] r_op_count;

  always_ff @(posedge clk) begin
    if (!rst)                                          r_op_count <= '0;
    else if (w_rsp_fire && r_op_count != '1)           r_op_count <= r_op_count + 1'b1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: expected responses are queued in hand-derived
// grant order and a negedge monitor pops and compares each response handshake.
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int BW = 3;
  localparam int RW = 6;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [RW-1:0]   rsp_result;
  logic            rsp_ready = 1'b0;
  logic            busy;
`ifdef MULT_SHARE_STATS_EN
  logic [15:0]     op_count;
`endif

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .A_W(AW), .B_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef MULT_SHARE_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [RW-1:0] res;
  } rsp_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
  } op_t;

  rsp_t sb[$];
  op_t  pend[N][$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_gap = 1'b0;
  int   hs_cnt  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic post(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    op_t op;
    op.a = a;
    op.b = b;
    pend[i].push_back(op);
  endtask

  task automatic expect_rsp(input logic [IW-1:0] id, input logic [RW-1:0] res);
    rsp_t r;
    r.id  = id;
    r.res = res;
    sb.push_back(r);
  endtask

  function automatic bit all_idle();
    bit e;
    e = (sb.size() == 0) && (req_valid == '0) && !busy;
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      if (all_idle()) break;
      step();
    end
    check(name, (k < 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Requester model: holds valid and operands until its handshake, then loads its next op.
  initial begin
    logic [N-1:0] hs;
    op_t          op;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && pend[i].size() != 0) begin
          op = pend[i].pop_front();
          req_a[i*AW +: AW] = op.a;
          req_b[i*BW +: BW] = op.b;
          req_valid[i]      = 1'b1;
        end
      end
    end
  end

  // Response monitor: scoreboard compare, hold stability under backpressure, spacing.
  initial begin
    int            cyc;
    int            gap_prev;
    logic          held;
    logic [IW-1:0] s_id;
    logic [RW-1:0] s_res;
    rsp_t          e;
    cyc      = 0;
    gap_prev = -1;
    held     = 1'b0;
    s_id     = '0;
    s_res    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      check("req_ready_onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (!chk_gap) gap_prev = -1;
      if (!rst) begin
        held   = 1'b0;
        hs_cnt = 0;
      end else if (rsp_valid) begin
        if (busy) check("ready_while_busy", 32'(req_ready), 32'd0);
        if (held) begin
          check("hold_id", 32'(rsp_id), 32'(s_id));
          check("hold_result", 32'(rsp_result), 32'(s_res));
        end
        if (rsp_ready) begin
          held = 1'b0;
          hs_cnt++;
          if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
          end
          if (chk_gap) begin
            if (gap_prev >= 0) check("rsp_spacing", 32'(cyc - gap_prev), 32'd3);
            gap_prev = cyc;
          end
        end else begin
          held  = 1'b1;
          s_id  = rsp_id;
          s_res = rsp_result;
        end
      end else begin
        if (held) check("rsp_valid_dropped", 32'(rsp_valid), 32'd1);
        held = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    // Reset state
    rst = 1'b0;
    step();
    step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;

    // Single request with cycle-exact latency
    rsp_ready = 1'b1;
    post(2, 3'd3, 3'd3);
    expect_rsp(2'd2, 6'd9);
    step();
    check("t1_grant", 32'(req_ready), 32'b0100);
    step();
    check("t1_calc_busy", 32'(busy), 32'd1);
    check("t1_calc_valid", 32'(rsp_valid), 32'd0);
    check("t1_calc_ready", 32'(req_ready), 32'd0);
    step();
    check("t1_resp_valid", 32'(rsp_valid), 32'd1);
    check("t1_resp_id", 32'(rsp_id), 32'd2);
    check("t1_resp_result", 32'(rsp_result), 32'd9);
    step();
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_valid_fall", 32'(rsp_valid), 32'd0);
    wait_drain("t1_drain");

    // Simultaneous req 0 and req 1 from reset; boundaries 7*7 and 0*5
    do_reset();
    post(0, 3'd7, 3'd7);
    post(1, 3'd0, 3'd5);
    expect_rsp(2'd0, 6'd49);
    expect_rsp(2'd1, 6'd0);
    wait_drain("t2_drain");

    // All four continuously valid: order 0,1,2,3,0,1 at one response per 3 cycles
    do_reset();
    chk_gap = 1'b1;
    post(0, 3'd7, 3'd1);
    post(0, 3'd2, 3'd3);
    post(1, 3'd5, 3'd5);
    post(1, 3'd6, 3'd7);
    post(2, 3'd4, 3'd4);
    post(3, 3'd1, 3'd6);
    expect_rsp(2'd0, 6'd7);
    expect_rsp(2'd1, 6'd25);
    expect_rsp(2'd2, 6'd16);
    expect_rsp(2'd3, 6'd6);
    expect_rsp(2'd0, 6'd6);
    expect_rsp(2'd1, 6'd42);
    wait_drain("t3_drain");
    chk_gap = 1'b0;

    // Backpressure in RESP for 5 cycles while another requester waits
    rsp_ready = 1'b0;
    post(3, 3'd6, 3'd5);
    expect_rsp(2'd3, 6'd30);
    expect_rsp(2'd0, 6'd12);
    for (k = 0; k < 20; k++) begin
      if (rsp_valid) break;
      step();
    end
    check("t4_reach_resp", (k < 20) ? 32'd1 : 32'd0, 32'd1);
    post(0, 3'd3, 3'd4);
    repeat (5) begin
      step();
      check("t4_bp_valid", 32'(rsp_valid), 32'd1);
      check("t4_bp_id", 32'(rsp_id), 32'd3);
      check("t4_bp_result", 32'(rsp_result), 32'd30);
      check("t4_bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("t4_release_valid", 32'(rsp_valid), 32'd0);
    check("t4_release_busy", 32'(busy), 32'd0);
    wait_drain("t4_drain");

    // Reset during CALC: op discarded, pointer back to N_REQ-1
    post(1, 3'd2, 3'd2);
    for (k = 0; k < 20; k++) begin
      if (busy) break;
      step();
    end
    check("t5_reach_calc", (k < 20) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b0;
    step();
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_id", 32'(rsp_id), 32'd0);
    check("t5_rst_result", 32'(rsp_result), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    repeat (4) step();
    post(0, 3'd1, 3'd1);
    post(2, 3'd3, 3'd2);
    expect_rsp(2'd0, 6'd1);
    expect_rsp(2'd2, 6'd6);
    wait_drain("t5_drain");

    check("sb_leftover", 32'(sb.size()), 32'd0);
`ifdef MULT_SHARE_STATS_EN
    check("op_count", 32'(op_count), 32'(hs_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
